pc_sequencer: RTL and testbench

Parametrised program-counter sequencer. It is the next generation of the fixed 6-bit PC register and sits at the front of the instruction-fetch path, driving the instruction-memory address. Each cycle it selects the next PC from one of several sources: hold, sequential increment, PC-relative branch, absolute jump, or subroutine return. It adds stall handling, a configurable reset vector and an optional hardware return-address stack (RAS).

---
 rtl/pc_seq_if.sv | 27 ++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// pc_sequencer request/response bundle.
// The fetch-control side is the master; the sequencer is the slave.
interface pc_seq_if #(
    parameter int PC_WIDTH = 6
);
    logic                stall;
    logic                branch;
    logic [PC_WIDTH-1:0] branch_off;
    logic                jump;
    logic [PC_WIDTH-1:0] jump_tgt;
    logic                call;
    logic                ret;
    logic [PC_WIDTH-1:0] pc_out;
    logic [PC_WIDTH-1:0] pc_next;
    logic                ras_ovf;
    logic                ras_unf;

    modport master (
        output stall, branch, branch_off, jump, jump_tgt, call, ret,
        input  pc_out, pc_next, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, branch, branch_off, jump, jump_tgt, call, ret,
        output pc_out, pc_next, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold/step/branch/jump/return next-PC select.
// Define PC_RAS_EN to build the circular return-address stack.
module pc_sequencer #(
    parameter int PC_WIDTH  = 6,
    parameter int RESET_PC  = 0,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_seq_if.slave bus
);
    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t RST_PC = pc_t'(RESET_PC);
    localparam pc_t STEP_W = pc_t'(STEP);

    pc_t pc_q;
    pc_t pc_d;
    pc_t seq_pc;
    pc_t br_pc;

    assign seq_pc = pc_q + STEP_W;
    assign br_pc  = pc_q + bus.branch_off;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t FULL = cnt_t'(RAS_DEPTH);

    pc_t  ras_q [RAS_DEPTH];
    pc_t  ras_d [RAS_DEPTH];
    ptr_t ptr_q, ptr_d;
    ptr_t top_idx;
    cnt_t cnt_q, cnt_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // ptr_q is the next write slot, so the top sits just below it
    assign top_idx = ptr_q - ptr_t'(1);

    always_comb begin
        pc_d  = seq_pc;
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ret) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                pc_d  = ras_q[top_idx];
                ptr_d = top_idx;
                cnt_d = cnt_q - cnt_t'(1);
            end
        end else if (bus.jump) begin
            pc_d = bus.jump_tgt;
            if (bus.call) begin
                // when full, ptr_q already points at the oldest entry
                ras_d[ptr_q] = seq_pc;
                ptr_d        = ptr_q + ptr_t'(1);
                if (cnt_q == FULL) ovf_d = 1'b1;
                else               cnt_d = cnt_q + cnt_t'(1);
            end
        end else if (bus.branch) begin
            pc_d = br_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;
`else
    localparam int unused_depth = RAS_DEPTH;

    logic unused_ras;

    assign unused_ras = &{1'b0, bus.call, bus.ret};

    always_comb begin
        pc_d = seq_pc;
        if (bus.stall)       pc_d = pc_q;
        else if (bus.jump)   pc_d = bus.jump_tgt;
        else if (bus.branch) pc_d = br_pc;
    end

    assign bus.ras_ovf = 1'b0;
    assign bus.ras_unf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) pc_q <= RST_PC;
        else      pc_q <= pc_d;
    end

    assign bus.pc_out  = pc_q;
    assign bus.pc_next = rst ? pc_d : RST_PC;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (PC_WIDTH=6, RESET_PC=0, STEP=1, RAS_DEPTH=4).
// Follows PC_RAS_EN the same way the design does.
module tb_pc_sequencer;
    localparam int W = 6;
    localparam int D = 4;

    typedef logic [W-1:0] pc_t;
    typedef struct {
        pc_t pc;
        bit  ovf;
        bit  unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pc_seq_if #(.PC_WIDTH(W)) bus ();

    pc_sequencer #(
        .PC_WIDTH (W),
        .RESET_PC (0),
        .STEP     (1),
        .RAS_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    exp_t exp_q[$];
    pc_t  ras_m[$];
    pc_t  m_pc  = '0;
    bit   m_ovf = 1'b0;
    bit   m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    endtask

    task automatic cyc(input bit r, input bit s, input bit b, input pc_t off,
                       input bit j, input pc_t t, input bit c, input bit rt);
        pc_t  nx;
        bit   nov;
        bit   nun;
        exp_t e;
        rst            = r;
        bus.stall      = s;
        bus.branch     = b;
        bus.branch_off = off;
        bus.jump       = j;
        bus.jump_tgt   = t;
        bus.call       = c;
        bus.ret        = rt;
        nov = m_ovf;
        nun = m_unf;
        if (!r) begin
            nx  = '0;
            nov = 1'b0;
            nun = 1'b0;
            ras_m.delete();
        end else if (s) begin
            nx = m_pc;
`ifdef PC_RAS_EN
        end else if (rt) begin
            if (ras_m.size() == 0) begin
                nx  = m_pc + pc_t'(1);
                nun = 1'b1;
            end else begin
                nx = ras_m.pop_back();
            end
        end else if (j) begin
            if (c) begin
                if (ras_m.size() == D) begin
                    void'(ras_m.pop_front());
                    nov = 1'b1;
                end
                ras_m.push_back(m_pc + pc_t'(1));
            end
            nx = t;
`else
        end else if (j) begin
            nx = t;
`endif
        end else if (b) begin
            nx = m_pc + off;
        end else begin
            nx = m_pc + pc_t'(1);
        end
        #1;
        chk("pc_next", 32'(bus.pc_next), 32'(nx));
        exp_q.push_back('{pc: nx, ovf: nov, unf: nun});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("pc_out", 32'(bus.pc_out), 32'(e.pc));
        chk("ras_ovf", 32'(bus.ras_ovf), 32'(e.ovf));
        chk("ras_unf", 32'(bus.ras_unf), 32'(e.unf));
        m_pc  = nx;
        m_ovf = nov;
        m_unf = nun;
    endtask

    task automatic idle();
        cyc(1, 0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic jmp(input pc_t t);
        cyc(1, 0, 0, '0, 1, t, 0, 0);
    endtask

    task automatic call_to(input pc_t t);
        cyc(1, 0, 0, '0, 1, t, 1, 0);
    endtask

    task automatic ret_op();
        cyc(1, 0, 0, '0, 0, '0, 0, 1);
    endtask

    initial begin
        bus.stall      = 1'b0;
        bus.branch     = 1'b0;
        bus.branch_off = '0;
        bus.jump       = 1'b0;
        bus.jump_tgt   = '0;
        bus.call       = 1'b0;
        bus.ret        = 1'b0;
        @(negedge clk);

        cyc(0, 0, 0, '0, 0, '0, 0, 0);
        cyc(0, 0, 0, '0, 0, '0, 0, 0);
        repeat (3) idle();

        jmp(6'd63);
        idle();
        jmp(6'd2);
        cyc(1, 0, 1, 6'b111110, 0, '0, 0, 0);
        jmp(6'd60);
        cyc(1, 0, 1, 6'd5, 0, '0, 0, 0);

        jmp(6'd5);
        cyc(1, 1, 0, '0, 1, 6'd20, 0, 0);
        cyc(1, 1, 1, 6'd9, 0, '0, 1, 1);
        idle();

        jmp(6'd10);
        call_to(6'd30);
        call_to(6'd40);
        ret_op();
        ret_op();

        cyc(0, 0, 0, '0, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) call_to(pc_t'(8 * i + 3));
        for (int i = 0; i < 4; i++) ret_op();
        ret_op();
        cyc(0, 0, 0, '0, 0, '0, 0, 0);

        call_to(6'd30);
        ret_op();
        cyc(1, 0, 0, '0, 1, 6'd50, 1, 1);
        cyc(1, 1, 0, '0, 0, '0, 0, 1);

        for (int i = 0; i < 200; i++) begin
            cyc($urandom_range(39, 0) != 0,
                $urandom_range(5, 0) == 0,
                $urandom_range(1, 0) == 1,
                pc_t'($urandom),
                $urandom_range(2, 0) == 0,
                pc_t'($urandom),
                $urandom_range(1, 0) == 1,
                $urandom_range(3, 0) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
